regfile_mp: RTL and testbench

//  Multi-port register file: one write port with byte strobes, NRD independent read ports.
//  - Reads have 1-cycle latency with a valid pulse per port.
//  - Reads and writes proceed concurrently, with optional write-to-read bypass.
//  - Selected registers are write-protected; illegal accesses are flagged and counted.
//  - Sits between the bus slave and config/status logic as the shared CSR store.

---
 rtl/regfile_mp.sv | 143 ++++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: shared CSR store with one byte-strobed write port and NRD read ports.
// Reads return registered data one cycle after the request and pulse a valid bit.
// Read-only and unmapped addresses reject writes. Unmapped reads return zero and
// raise an error. A saturating counter tracks every error event.
`timescale 1ns/1ps
module regfile_mp #(
    parameter int              WIDTH   = 32,
    parameter int              DEPTH   = 16,
    parameter int              ADDR    = 4,
    parameter int              NRD     = 2,
    parameter logic [DEPTH-1:0] RO_MASK = '0,
    parameter int              BYPASS  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [ADDR-1:0]        i_wr_addr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic [WIDTH/8-1:0]     i_wr_strb,
    input  logic [NRD-1:0]         i_rd_en,
    input  logic [NRD*ADDR-1:0]    i_rd_addr,
    output logic [NRD*WIDTH-1:0]   o_rd_data,
    output logic [NRD-1:0]         o_rd_valid,
    output logic                   o_wr_err,
    output logic [NRD-1:0]         o_rd_err,
    output logic [7:0]             o_err_cnt
);

    localparam int NB   = WIDTH / 8;
    localparam int NREG = 1 << ADDR;

    // Storage covers the full address space. Slots at DEPTH and above can never
    // be written, so they stay at zero and are trimmed by synthesis.
    logic [WIDTH-1:0] r_mem [NREG];

    logic [NREG-1:0]  w_mapped;     // address exists
    logic [NREG-1:0]  w_locked;     // write to this address is rejected
    logic             w_wr_ok;
    logic             w_wr_rej;
    logic [WIDTH-1:0] w_wr_merged;  // target register after applying strobes
    logic [NRD-1:0]   w_rd_rej;
    logic [3:0]       w_evt;
    logic [8:0]       w_sum;
    logic             r_wr_err;
    logic [7:0]       r_err_cnt;

    // Per-address decode. These are constant and fold away.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_map
            if (gi < DEPTH) begin : g_in
                assign w_mapped[gi] = 1'b1;
                assign w_locked[gi] = RO_MASK[gi];
            end else begin : g_out
                assign w_mapped[gi] = 1'b0;
                assign w_locked[gi] = 1'b1;
            end
        end
    endgenerate

    assign w_wr_ok  = i_wr_en & ~w_locked[i_wr_addr];
    assign w_wr_rej = i_wr_en &  w_locked[i_wr_addr];

    // Build the post-write value. Unstrobed bytes keep their stored contents.
    always_comb begin
        w_wr_merged = r_mem[i_wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (i_wr_strb[b]) begin
                w_wr_merged[b*8 +: 8] = i_wr_data[b*8 +: 8];
            end
        end
    end

    // Register array update. Only legal writes reach storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wr_addr] <= w_wr_merged;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR-1:0]  w_addr;
            logic             w_hit;
            logic [WIDTH-1:0] w_val;
            logic [WIDTH-1:0] r_data;
            logic             r_valid;
            logic             r_err;

            assign w_addr       = i_rd_addr[gi*ADDR +: ADDR];
            assign w_hit        = (BYPASS != 0) && w_wr_ok && (w_addr == i_wr_addr);
            assign w_val        = !w_mapped[w_addr] ? '0 :
                                  (w_hit ? w_wr_merged : r_mem[w_addr]);
            assign w_rd_rej[gi] = i_rd_en[gi] & ~w_mapped[w_addr];

            // Read pipeline stage. Data holds while the port is idle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_valid <= i_rd_en[gi];
                    r_err   <= w_rd_rej[gi];
                    if (i_rd_en[gi]) begin
                        r_data <= w_val;
                    end
                end
            end

            assign o_rd_data[gi*WIDTH +: WIDTH] = r_data;
            assign o_rd_valid[gi]               = r_valid;
            assign o_rd_err[gi]                 = r_err;
        end
    endgenerate

    // Count this cycle's error events. The counter moves on the same edge as the error pulses.
    always_comb begin
        w_evt = {3'b000, w_wr_rej};
        for (int i = 0; i < NRD; i++) begin
            w_evt = w_evt + {3'b000, w_rd_rej[i]};
        end
        w_sum = {1'b0, r_err_cnt} + {5'b00000, w_evt};
    end

    // Write-reject pulse and the saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_err  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_wr_err  <= w_wr_rej;
            r_err_cnt <= w_sum[8] ? 8'hFF : w_sum[7:0];
        end
    end

    assign o_wr_err  = r_wr_err;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus for regfile_mp, checked against a
// behavioural register-file model (array and arithmetic masks).
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int              W   = 32;
    localparam int              D   = 12;
    localparam int              A   = 4;
    localparam int              N   = 2;
    localparam int              BYP = 1;
    localparam logic [D-1:0]    RO  = 12'h004;

    logic           clk;
    logic           rst;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [W-1:0]   wr_data;
    logic [W/8-1:0] wr_strb;
    logic [N-1:0]   rd_en;
    logic [N*A-1:0] rd_addr;
    logic [N*W-1:0] rd_data;
    logic [N-1:0]   rd_valid;
    logic           wr_err;
    logic [N-1:0]   rd_err;
    logic [7:0]     err_cnt;

    regfile_mp #(
        .WIDTH(W), .DEPTH(D), .ADDR(A), .NRD(N), .RO_MASK(RO), .BYPASS(BYP)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_wr_err(wr_err),
        .o_rd_err(rd_err), .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [D];
    logic [31:0] e_data [N];
    logic [N-1:0] e_valid;
    logic [N-1:0] e_rerr;
    logic        e_werr;
    int          e_cnt;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        for (int p = 0; p < N; p++) e_data[p] = '0;
        e_valid = '0;
        e_rerr  = '0;
        e_werr  = 1'b0;
        e_cnt   = 0;
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < N; p++) begin
            chk($sformatf("%s.data%0d", tag, p), rd_data[p*W +: W], e_data[p]);
            chk($sformatf("%s.valid%0d", tag, p), {31'b0, rd_valid[p]}, {31'b0, e_valid[p]});
            chk($sformatf("%s.rderr%0d", tag, p), {31'b0, rd_err[p]}, {31'b0, e_rerr[p]});
        end
        chk($sformatf("%s.wrerr", tag), {31'b0, wr_err}, {31'b0, e_werr});
        chk($sformatf("%s.errcnt", tag), {24'b0, err_cnt}, e_cnt[31:0]);
    endtask

    // One transaction: drive inputs, predict from the model, clock, then compare.
    task automatic step(input logic we, input int wa, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [1:0] re, input int ra0, input int ra1, input string tag);
        logic        ro;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] merged;
        int          ra;
        int          adds;
        wr_en   = we;
        wr_addr = wa[A-1:0];
        wr_data = wd;
        wr_strb = ws;
        rd_en   = re;
        rd_addr = {ra1[A-1:0], ra0[A-1:0]};

        ro     = (wa < D) ? RO[wa] : 1'b1;
        legal  = we && !ro;
        mask   = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        merged = legal ? ((m_mem[wa] & ~mask) | (wd & mask)) : 32'h0;
        adds   = 0;
        for (int p = 0; p < N; p++) begin
            ra = (p == 0) ? ra0 : ra1;
            if (re[p]) begin
                e_valid[p] = 1'b1;
                if (ra >= D) begin
                    e_data[p] = '0;
                    e_rerr[p] = 1'b1;
                    adds++;
                end else begin
                    e_rerr[p] = 1'b0;
                    e_data[p] = (BYP != 0 && legal && ra == wa) ? merged : m_mem[ra];
                end
            end else begin
                e_valid[p] = 1'b0;
                e_rerr[p]  = 1'b0;
            end
        end
        e_werr = we && !legal;
        if (e_werr) adds++;
        e_cnt = (e_cnt + adds > 255) ? 255 : e_cnt + adds;
        if (legal) m_mem[wa] = merged;

        @(posedge clk);
        #1;
        $display("[%0t] %s we=%b wa=%0d wd=%h ws=%h re=%b ra=%0d/%0d -> d0=%h d1=%h v=%b cnt=%0d",
                 $time, tag, we, wa, wd, ws, re, ra0, ra1,
                 rd_data[31:0], rd_data[63:32], rd_valid, err_cnt);
        check_all(tag);
    endtask

    initial begin
        int wa;
        int r0;
        int r1;
        n_vec   = 0;
        n_err   = 0;
        clk     = 1'b0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_strb = '0;
        rd_en   = '0;
        rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // All mapped addresses read back zero on both ports
        for (int a = 0; a < D; a++) step(1'b0, 0, 32'h0, 4'h0, 2'b11, a, D - 1 - a, "t1_read");
        step(1'b0, 0, 32'h0, 4'h0, 2'b00, 0, 0, "t1_idle");

        // Byte-strobed partial write
        step(1'b1, 3, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, "t2_wr_full");
        step(1'b1, 3, 32'h00001122, 4'h1, 2'b00, 0, 0, "t2_wr_byte");
        step(1'b0, 0, 32'h0, 4'h0, 2'b01, 3, 0, "t2_rd");
        chk("t2_const", rd_data[31:0], 32'hDEADBE22);

        // Same-edge write and read on both ports: bypassed new value
        step(1'b1, 5, 32'hA5A5A5A5, 4'hF, 2'b11, 5, 5, "t3_bypass");
        chk("t3_const_p0", rd_data[31:0], 32'hA5A5A5A5);
        chk("t3_const_p1", rd_data[63:32], 32'hA5A5A5A5);

        // Write to a read-only register, then read it, then read an unmapped address
        step(1'b1, 2, 32'hFFFFFFFF, 4'hF, 2'b00, 0, 0, "t4_ro_wr");
        chk("t4_werr_const", {31'b0, wr_err}, 32'd1);
        chk("t4_cnt1_const", {24'b0, err_cnt}, 32'd1);
        step(1'b0, 0, 32'h0, 4'h0, 2'b01, 2, 0, "t4_ro_rd");
        chk("t4_ro_data_const", rd_data[31:0], 32'h0);
        step(1'b0, 0, 32'h0, 4'h0, 2'b10, 0, 13, "t4_oor_rd");
        chk("t4_rerr_const", {31'b0, rd_err[1]}, 32'd1);
        chk("t4_cnt2_const", {24'b0, err_cnt}, 32'd2);

        // Randomized traffic, with frequent address collisions
        for (int k = 0; k < 200; k++) begin
            wa = $urandom_range(0, 15);
            r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            r1 = ($urandom_range(0, 3) == 0) ? r0 : $urandom_range(0, 15);
            step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), r0, r1, "rand");
        end

        // Counter saturation
        for (int k = 0; k < 300; k++) step(1'b1, 14, 32'h0, 4'hF, 2'b00, 0, 0, "t5_sat");
        chk("t5_sat_const", {24'b0, err_cnt}, 32'd255);
        step(1'b1, 15, 32'h0, 4'hF, 2'b11, 12, 13, "t5_hold");
        chk("t5_hold_const", {24'b0, err_cnt}, 32'd255);

        // Asynchronous reset in the middle of a read burst
        step(1'b0, 0, 32'h0, 4'h0, 2'b11, 3, 5, "t6_burst");
        step(1'b0, 0, 32'h0, 4'h0, 2'b11, 5, 3, "t6_burst");
        step(1'b0, 0, 32'h0, 4'h0, 2'b11, 13, 3, "t6_burst");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        rd_en = 2'b00;
        @(posedge clk);
        #1;
        check_all("t6_in_rst");
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 0, 32'h0, 4'h0, 2'b00, 0, 0, "t6_idle");
        step(1'b0, 0, 32'h0, 4'h0, 2'b01, 3, 0, "t6_first");
        chk("t6_first_valid_const", {30'b0, rd_valid}, 32'd1);
        step(1'b0, 0, 32'h0, 4'h0, 2'b00, 0, 0, "t6_drop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
